// File: rtl/seq_word_ctrl_pkg.sv
// seq_word_pkg: shared definitions for the seq_word_ctrl slice.
//   - state_t       : controller FSM encoding (IDLE, SHIFT, REPORT)
//   - *_DEF         : default parameter values for the top and matcher
//   - sat_inc()     : saturating increment used by the match counter
package seq_word_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int WORD_W_DEF  = 16;
  localparam int PAT_MAX_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 5;

  // Returns v+1, or v unchanged once it has reached max.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_word_ctrl_pat_match.sv
// seq_pat_match: serial pattern matcher with overlapping detection.
// Keeps the last PAT_MAX received bits (bit 0 = newest) and a fill counter
// saying how many of them are real. hit is combinational and reflects the
// state the registers will hold after this cycle's shift.
// Ports:
//   clk, rst (async, active-low)
//   shift_en : shift bit_in into the history this cycle
//   bit_in   : serial data bit
//   clear    : synchronous clear of history and fill
//   pat, len : pattern (bit 0 = newest) and its length, valid range 1..PAT_MAX
//   hit      : a match completes with this cycle's shift
module seq_pat_match
  import seq_word_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic               clear,
  input  logic [PAT_MAX-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  localparam int FILL_W = $clog2(PAT_MAX + 1);

  logic [PAT_MAX-1:0] history, history_next, mask;
  logic [FILL_W-1:0]  fill, fill_next;
  logic               len_ok;

  assign history_next = {history[PAT_MAX-2:0], bit_in};
  assign fill_next    = (fill == FILL_W'(PAT_MAX)) ? fill : fill + FILL_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
    // Out-of-range lengths never match, including the empty pattern.
    len_ok = (len != '0) && (int'(len) <= PAT_MAX);
    hit    = shift_en && len_ok && (int'(fill_next) >= int'(len)) &&
             (((history_next ^ pat) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= history_next;
      fill    <= fill_next;
    end
  end

endmodule

// File: rtl/seq_word_ctrl.sv
// seq_word_ctrl: takes parallel words on a valid/ready handshake, shifts them
// MSB-first through seq_pat_match one bit per clock, and returns the number of
// (overlapping) pattern matches per word on a valid/ready result port.
// Ports:
//   clk, rst (async, active-low)
//   cfg_we, cfg_pat, cfg_len   : configuration write, honoured only in IDLE
//   in_valid, in_data, in_ready: word input handshake
//   out_valid, out_count, out_ready: per-word match count handshake
//   ind  : registered one-cycle pulse per detected match
//   busy : high while shifting or reporting
// Build option: define SEQ_WORD_CARRY_EN to keep matcher history across words
// (cleared only by reset or a config write), so patterns spanning a word
// boundary are counted in the later word.
module seq_word_ctrl
  import seq_word_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [CNT_W-1:0]   out_count,
  input  logic               out_ready,
  output logic               ind,
  output logic               busy
);

  localparam int          BIDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  state_t             state, state_nx;
  logic               run;
  logic               accept, shift_en, cfg_load, clear, hit, bit_in;
  logic [WORD_W-1:0]  word;
  logic [BIDX_W-1:0]  bit_idx;
  logic [PAT_MAX-1:0] pat_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [CNT_W-1:0]   count;

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    shift_en = 1'b0;
    cfg_load = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_load = cfg_we;
        accept   = in_valid && run;
        if (accept) state_nx = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_idx == '0) state_nx = REPORT;
      end
      REPORT: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SEQ_WORD_CARRY_EN
  assign clear = cfg_load;
`else
  assign clear = accept;
`endif

  assign in_ready  = run && (state == IDLE);
  assign out_valid = (state == REPORT);
  assign busy      = (state != IDLE);
  assign out_count = count;
  assign bit_in    = word[bit_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg <= '0;
      len_reg <= '0;
    end else if (cfg_load) begin
      pat_reg <= cfg_pat;
      len_reg <= cfg_len;
    end
  end

  // Word payload is data only; it is always reloaded before it is used.
  always_ff @(posedge clk) begin
    if (accept) word <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx <= '0;
      count   <= '0;
      ind     <= 1'b0;
    end else begin
      ind <= hit;
      if (accept) begin
        bit_idx <= BIDX_W'(WORD_W - 1);
        count   <= '0;
      end else begin
        if (shift_en && (bit_idx != '0)) bit_idx <= bit_idx - BIDX_W'(1);
        if (hit) count <= CNT_W'(sat_inc(32'(count), CNT_MAX));
      end
    end
  end

  seq_pat_match #(
    .PAT_MAX(PAT_MAX),
    .LEN_W  (LEN_W)
  ) u_match (
    .clk     (clk),
    .rst     (rst),
    .shift_en(shift_en),
    .bit_in  (bit_in),
    .clear   (clear),
    .pat     (pat_reg),
    .len     (len_reg),
    .hit     (hit)
  );

endmodule
